// File: rtl/mdr_pkg.sv
// Shared types and constants for the memory data register unit.
// Subword transfers are enabled by defining MDR_SUBWORD_EN.
package mdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } mdr_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 16;

endpackage

// File: rtl/mdr_mem_unit_format.sv
// Subword formatting: read sign/zero extension, write lane replication and byte enables.
// Only instantiated when MDR_SUBWORD_EN is defined; size code 2'b11 falls through to word.
module mdr_load_format
    import mdr_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [1:0]          size_i,
    input  logic                uns_i,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic [DATA_W-1:0]   q_i,
    output logic [DATA_W-1:0]   rd_ext_o,
    output logic [DATA_W-1:0]   wr_data_o,
    output logic [DATA_W/8-1:0] be_o
);

    localparam int NB = DATA_W / 8;

    always_comb begin
        rd_ext_o  = rdata_i;
        wr_data_o = q_i;
        be_o      = '1;
        case (size_i)
            SZ_BYTE: begin
                rd_ext_o      = {DATA_W{~uns_i & rdata_i[7]}};
                rd_ext_o[7:0] = rdata_i[7:0];
                for (int i = 0; i < NB; i++) wr_data_o[i*8 +: 8] = q_i[7:0];
                be_o    = '0;
                be_o[0] = 1'b1;
            end
            SZ_HALF: begin
                rd_ext_o       = {DATA_W{~uns_i & rdata_i[15]}};
                rd_ext_o[15:0] = rdata_i[15:0];
                // Even lanes take the low byte of the half, odd lanes the high byte.
                for (int i = 0; i < NB; i++) wr_data_o[i*8 +: 8] = q_i[(i%2)*8 +: 8];
                be_o      = '0;
                be_o[1:0] = 2'b11;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdr_mem_unit.sv
// Memory data register with a req/ready memory handshake, wait states and timeout abort.
// Optional subword (byte/half) transfers under the MDR_SUBWORD_EN macro.
module mdr_mem_unit
    import mdr_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                Clear,
    input  logic [DATA_W-1:0]   BusMuxOut,
    input  logic                MDRIn,
    input  logic                MDRead,
    input  logic                MemWrite,
    input  logic [DATA_W-1:0]   MDataIn,
    input  logic                mem_ready,
`ifdef MDR_SUBWORD_EN
    input  logic [1:0]          Size,
    input  logic                Unsigned,
`endif
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   Q,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    mdr_state_e          state_q, state_d;
    logic [DATA_W-1:0]   q_q, q_d, wdata_q, wdata_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                req_q, req_d, we_q, we_d, busy_q, busy_d;
    logic                done_q, done_d, err_q, err_d;
    logic [DATA_W-1:0]   rd_ext, wr_fmt;
    logic [DATA_W/8-1:0] be_fmt;

`ifdef MDR_SUBWORD_EN
    logic [1:0]          size_q;
    logic                uns_q;
    logic [DATA_W/8-1:0] be_q, be_d;

    // Write formatting happens at start (IDLE, live Size); read extension at completion (latched Size).
    mdr_load_format #(.DATA_W(DATA_W)) u_fmt (
        .size_i    ((state_q == ST_IDLE) ? Size : size_q),
        .uns_i     ((state_q == ST_IDLE) ? Unsigned : uns_q),
        .rdata_i   (MDataIn),
        .q_i       (q_q),
        .rd_ext_o  (rd_ext),
        .wr_data_o (wr_fmt),
        .be_o      (be_fmt)
    );

    always_ff @(posedge clk or posedge Clear) begin
        if (Clear) begin
            size_q <= SZ_WORD;
            uns_q  <= 1'b0;
            be_q   <= '1;
        end else begin
            be_q <= be_d;
            if (state_q == ST_IDLE && (MDRead || MemWrite)) begin
                size_q <= Size;
                uns_q  <= Unsigned;
            end
        end
    end

    assign mem_be = be_q;
`else
    assign rd_ext = MDataIn;
    assign wr_fmt = q_q;
    assign be_fmt = '1;
    assign mem_be = '1;
`endif

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef MDR_SUBWORD_EN
        be_d    = be_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (MDRead || MemWrite) begin
                    state_d = MDRead ? ST_RD_WAIT : ST_WR_WAIT;
                    req_d   = 1'b1;
                    we_d    = ~MDRead;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    if (!MDRead) wdata_d = wr_fmt;
`ifdef MDR_SUBWORD_EN
                    be_d = be_fmt;
`endif
                end else if (MDRIn) begin
                    q_d = BusMuxOut;
                end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
                // Ready is checked before the timeout so a late ready still succeeds.
                if (mem_ready || (TIMEOUT_CYC != 0 && cnt_q == CNT_LAST)) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = ~mem_ready;
                    if (mem_ready && state_q == ST_RD_WAIT) q_d = rd_ext;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Clear) begin
        if (Clear) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign Q         = q_q;
    assign mem_wdata = wdata_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mdr_mem_unit.sv
// Randomized bench for mdr_mem_unit (TIMEOUT_CYC=4); subword checks run when MDR_SUBWORD_EN is defined.
module tb_mdr_mem_unit;

    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          Clear, MDRIn, MDRead, MemWrite, mem_ready;
    logic [DW-1:0] BusMuxOut, MDataIn;
    logic          mem_req, mem_we, busy, done, err;
    logic [DW-1:0] mem_wdata, Q;
    logic [3:0]    mem_be;
`ifdef MDR_SUBWORD_EN
    logic [1:0]    Size;
    logic          Unsigned;
`endif

    int            vec_cnt = 0;
    int            err_cnt = 0;
    logic [DW-1:0] exp_q;

    always #5 clk = ~clk;

    mdr_mem_unit #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .Clear     (Clear),
        .BusMuxOut (BusMuxOut),
        .MDRIn     (MDRIn),
        .MDRead    (MDRead),
        .MemWrite  (MemWrite),
        .MDataIn   (MDataIn),
        .mem_ready (mem_ready),
`ifdef MDR_SUBWORD_EN
        .Size      (Size),
        .Unsigned  (Unsigned),
`endif
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .Q         (Q),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        Clear = 1'b1;
        #3;
        vec_cnt++;
        if ({Q, mem_wdata, mem_req, mem_we, busy, done, err, mem_be} !== {64'h0, 5'b0, 4'hF}) begin
            err_cnt++;
            $display("FAIL reset: got Q=%h wd=%h req=%b we=%b busy=%b done=%b err=%b be=%b want all 0, be=1111",
                     Q, mem_wdata, mem_req, mem_we, busy, done, err, mem_be);
        end
        Clear = 1'b0;
        exp_q = '0;
        tick;
    endtask

    task automatic test_load;
        for (int i = 0; i < 6; i++) begin
            logic [DW-1:0] d;
            d = (i == 0) ? 32'hDEADBEEF : $urandom;
            MDRIn = 1'b1; BusMuxOut = d;
            tick;
            MDRIn = 1'b0;
            exp_q = d;
            vec_cnt++;
            if (Q !== exp_q || mem_req !== 1'b0) begin
                err_cnt++;
                $display("FAIL load[%0d]: got Q=%h req=%b want Q=%h req=0", i, Q, mem_req, exp_q);
            end
        end
    endtask

    task automatic test_read;
        for (int i = 0; i < 7; i++) begin
            logic [DW-1:0] d;
            int w;
            d = (i == 0) ? 32'h12345678 : $urandom;
            w = (i == 0) ? 3 : int'($urandom_range(0, 3));
            MDRead = 1'b1;
            tick;
            MDRead = 1'b0;
            vec_cnt++;
            if ({mem_req, mem_we, busy, err} !== 4'b1010) begin
                err_cnt++;
                $display("FAIL read_start[%0d]: got req/we/busy/err=%b%b%b%b want 1010", i, mem_req, mem_we, busy, err);
            end
            for (int k = 0; k <= w; k++) begin
                MDataIn   = (k == w) ? d : $urandom;
                mem_ready = (k == w);
                MDRIn     = 1'($urandom);
                BusMuxOut = $urandom;
                vec_cnt++;
                if (mem_req !== 1'b1 || Q !== exp_q) begin
                    err_cnt++;
                    $display("FAIL read_wait[%0d.%0d]: got req=%b Q=%h want req=1 Q=%h", i, k, mem_req, Q, exp_q);
                end
                tick;
            end
            mem_ready = 1'b0; MDRIn = 1'b0;
            exp_q = d;
            vec_cnt++;
            if ({Q, done, busy, mem_req} !== {exp_q, 3'b100}) begin
                err_cnt++;
                $display("FAIL read_done[%0d]: got Q=%h done=%b busy=%b req=%b want Q=%h done=1 busy=0 req=0",
                         i, Q, done, busy, mem_req, exp_q);
            end
            tick;
            vec_cnt++;
            if (done !== 1'b0) begin
                err_cnt++;
                $display("FAIL read_pulse[%0d]: got done=%b want 0", i, done);
            end
        end
    endtask

    task automatic test_write;
        for (int i = 0; i < 4; i++) begin
            logic [DW-1:0] d;
            int w;
            d = (i == 0) ? 32'hA5A5A5A5 : $urandom;
            w = int'($urandom_range(0, 3));
            MDRIn = 1'b1; BusMuxOut = d;
            tick;
            exp_q = d;
            MDRIn = 1'b0; MemWrite = 1'b1;
            tick;
            MemWrite = 1'b0;
            vec_cnt++;
            if ({mem_req, mem_we, busy} !== 3'b111 || mem_wdata !== d) begin
                err_cnt++;
                $display("FAIL write_start[%0d]: got req/we/busy=%b%b%b wd=%h want 111 wd=%h",
                         i, mem_req, mem_we, busy, mem_wdata, d);
            end
            for (int k = 0; k <= w; k++) begin
                MDRIn = 1'b1; BusMuxOut = '0; MDRead = 1'b1; MemWrite = 1'b1;
                mem_ready = (k == w);
                tick;
            end
            MDRIn = 1'b0; MDRead = 1'b0; MemWrite = 1'b0; mem_ready = 1'b0;
            vec_cnt++;
            if ({done, mem_req, mem_we, busy} !== 4'b1000 || Q !== exp_q || mem_wdata !== d) begin
                err_cnt++;
                $display("FAIL write_done[%0d]: got done/req/we/busy=%b%b%b%b Q=%h wd=%h want 1000 Q=%h wd=%h",
                         i, done, mem_req, mem_we, busy, Q, mem_wdata, exp_q, d);
            end
            tick;
        end
    endtask

    task automatic test_timeout;
        int n;
        logic [DW-1:0] d;
        MDRead = 1'b1;
        tick;
        MDRead = 1'b0;
        n = 0;
        while (mem_req === 1'b1 && n < 20) begin
            MDataIn = $urandom;
            n++;
            tick;
        end
        vec_cnt++;
        if (n !== TO || {done, err, busy} !== 3'b110 || Q !== exp_q) begin
            err_cnt++;
            $display("FAIL timeout: got req_cycles=%0d done=%b err=%b busy=%b Q=%h want %0d 1 1 0 Q=%h",
                     n, done, err, busy, Q, TO, exp_q);
        end
        d = $urandom;
        MDRIn = 1'b1; BusMuxOut = d;
        tick;
        MDRIn = 1'b0;
        exp_q = d;
        vec_cnt++;
        if (err !== 1'b1 || Q !== exp_q) begin
            err_cnt++;
            $display("FAIL err_sticky: got err=%b Q=%h want err=1 Q=%h", err, Q, exp_q);
        end
        MDRead = 1'b1;
        tick;
        MDRead = 1'b0;
        vec_cnt++;
        if (err !== 1'b0) begin
            err_cnt++;
            $display("FAIL err_clear: got err=%b want 0", err);
        end
        d = $urandom;
        for (int k = 0; k < TO; k++) begin
            mem_ready = (k == TO - 1);
            MDataIn = d;
            tick;
        end
        mem_ready = 1'b0;
        exp_q = d;
        vec_cnt++;
        if ({done, err} !== 2'b10 || Q !== exp_q) begin
            err_cnt++;
            $display("FAIL ready_at_timeout: got done=%b err=%b Q=%h want done=1 err=0 Q=%h", done, err, Q, exp_q);
        end
        tick;
    endtask

    task automatic test_idle_ready;
        logic seen;
        seen = 1'b0;
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            seen = seen | done | busy | mem_req;
        end
        mem_ready = 1'b0;
        vec_cnt++;
        if (seen !== 1'b0 || Q !== exp_q) begin
            err_cnt++;
            $display("FAIL idle_ready: got activity=%b Q=%h want 0 Q=%h", seen, Q, exp_q);
        end
    endtask

    task automatic test_both;
        logic [DW-1:0] d;
        d = $urandom;
        MDRead = 1'b1; MemWrite = 1'b1;
        tick;
        MDRead = 1'b0; MemWrite = 1'b0;
        vec_cnt++;
        if ({mem_req, mem_we} !== 2'b10) begin
            err_cnt++;
            $display("FAIL both_req: got req=%b we=%b want req=1 we=0", mem_req, mem_we);
        end
        mem_ready = 1'b1; MDataIn = d;
        tick;
        mem_ready = 1'b0;
        exp_q = d;
        vec_cnt++;
        if (Q !== exp_q || done !== 1'b1) begin
            err_cnt++;
            $display("FAIL both_done: got Q=%h done=%b want Q=%h done=1", Q, done, exp_q);
        end
        tick;
    endtask

    task automatic test_clear_mid;
        MDRead = 1'b1;
        tick;
        MDRead = 1'b0;
        tick;
        #2 Clear = 1'b1;
        #1;
        exp_q = '0;
        vec_cnt++;
        if ({Q, mem_wdata, mem_req, mem_we, busy, done, err, mem_be} !== {64'h0, 5'b0, 4'hF}) begin
            err_cnt++;
            $display("FAIL clear_mid: got Q=%h wd=%h req=%b we=%b busy=%b done=%b err=%b be=%b want all 0, be=1111",
                     Q, mem_wdata, mem_req, mem_we, busy, done, err, mem_be);
        end
        #1 Clear = 1'b0;
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        vec_cnt++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL clear_no_done: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

`ifdef MDR_SUBWORD_EN
    task automatic test_subword;
        logic [DW-1:0] d, want;
        for (int i = 0; i < 6; i++) begin
            Size     = (i < 2) ? 2'b00 : 2'($urandom_range(0, 3));
            Unsigned = (i < 2) ? i[0] : 1'($urandom);
            d        = (i < 2) ? 32'h000000F0 : $urandom;
            if (Size == 2'b00)      want = Unsigned ? {24'h0, d[7:0]}  : DW'($signed(d[7:0]));
            else if (Size == 2'b01) want = Unsigned ? {16'h0, d[15:0]} : DW'($signed(d[15:0]));
            else                    want = d;
            MDRead = 1'b1;
            tick;
            MDRead = 1'b0; Size = 2'b10; Unsigned = 1'b0;
            mem_ready = 1'b1; MDataIn = d;
            tick;
            mem_ready = 1'b0;
            exp_q = want;
            vec_cnt++;
            if (Q !== exp_q) begin
                err_cnt++;
                $display("FAIL sub_read[%0d]: got Q=%h want %h", i, Q, exp_q);
            end
        end
        MDRIn = 1'b1; BusMuxOut = 32'h0000003C;
        tick;
        MDRIn = 1'b0; exp_q = 32'h0000003C;
        Size = 2'b00; MemWrite = 1'b1;
        tick;
        MemWrite = 1'b0; Size = 2'b10;
        vec_cnt++;
        if (mem_wdata !== 32'h3C3C3C3C || mem_be !== 4'b0001) begin
            err_cnt++;
            $display("FAIL sub_write: got wd=%h be=%b want 3c3c3c3c 0001", mem_wdata, mem_be);
        end
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        tick;
    endtask
`endif

    initial begin
        MDRIn = 1'b0; MDRead = 1'b0; MemWrite = 1'b0; mem_ready = 1'b0;
        BusMuxOut = '0; MDataIn = '0; Clear = 1'b0;
`ifdef MDR_SUBWORD_EN
        Size = 2'b10; Unsigned = 1'b0;
`endif
        test_reset;
        test_load;
        test_read;
        test_write;
        test_timeout;
        test_idle_ready;
        test_both;
        test_clear_mid;
`ifdef MDR_SUBWORD_EN
        test_subword;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
